vol_stats_finalize: RTL and testbench

//   Downstream of the voltage min/max/sum block. Once per measurement window it

---
 rtl/vol_stats_finalize_pkg.sv | 21 ++
 rtl/vol_stats_finalize_if.sv | 33 +++
 rtl/vol_stats_finalize_serial_divider.sv | 78 +++++++
 rtl/vol_stats_finalize.sv | 191 +++++++++++++++++++
 tb/tb_vol_stats_finalize.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vol_stats_finalize_pkg.sv
// Shared constants and FSM state type for the voltage statistics finalizer.
package vol_meas_pkg;

  localparam int DW_DEF      = 12;
  localparam int SW_DEF      = 32;
  localparam int NW_DEF      = 13;
  localparam int DIV_CYCLES  = 32;
  localparam int SQRT_CYCLES = 12;
  localparam int LATENCY     = 78;
  localparam int SAT_MAX     = 4095;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DIV_MEAN,
    DIV_SQ,
    SQRT,
    DONE
  } state_t;

endpackage

// File: rtl/vol_stats_finalize_if.sv
// Window-totals in / display-codes out bundle between the min/max/sum block,
// the finalizer and the readout logic.
interface vol_stats_if
  import vol_meas_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF,
  parameter int NW = NW_DEF
);
  logic          MEAN_FLAG;
  logic [SW-1:0] SUM_IN;
  logic [SW-1:0] SUMSQ_IN;
  logic [SW-1:0] MAX_IN;
  logic [SW-1:0] MIN_IN;
  logic [NW-1:0] N_SAMPLES;
  logic [DW-1:0] MEAN_OUT;
  logic [DW-1:0] RMS_OUT;
  logic [DW-1:0] VPP_OUT;
  logic          RESULT_VALID;
  logic          BUSY;
  logic          ERR_DIV0;
  logic          ERR_OVERRUN;

  modport master (
    output MEAN_FLAG, SUM_IN, SUMSQ_IN, MAX_IN, MIN_IN, N_SAMPLES,
    input  MEAN_OUT, RMS_OUT, VPP_OUT, RESULT_VALID, BUSY, ERR_DIV0, ERR_OVERRUN
  );

  modport slave (
    input  MEAN_FLAG, SUM_IN, SUMSQ_IN, MAX_IN, MIN_IN, N_SAMPLES,
    output MEAN_OUT, RMS_OUT, VPP_OUT, RESULT_VALID, BUSY, ERR_DIV0, ERR_OVERRUN
  );
endinterface

// File: rtl/vol_stats_finalize_serial_divider.sv
// Restoring serial divider: one quotient bit per clock. The start cycle already
// performs the first step, so the quotient is complete DIV_CYCLES edges after
// start and o_done pulses in the following cycle.
module serial_divider
  import vol_meas_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic          CLK,
  input  logic          RSTB,
  input  logic          i_start,
  input  logic [SW-1:0] i_dividend,
  input  logic [NW-1:0] i_divisor,
  output logic [SW-1:0] o_quot,
  output logic          o_done
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] L_LAST = CW'(DIV_CYCLES - 1);

  logic [SW-1:0] r_dvd;
  logic [SW-1:0] r_quot;
  logic [NW-1:0] r_rem;
  logic [NW-1:0] r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_active;
  logic          r_done;

  logic [SW-1:0] w_src_dvd;
  logic [SW-1:0] w_src_quot;
  logic [NW-1:0] w_src_rem;
  logic [NW-1:0] w_src_dvs;
  logic [NW:0]   w_sh;
  logic [NW:0]   w_diff;
  logic          w_ge;
  logic          w_last;
  logic          w_unused;

  // A start overrides the running state so the first step uses fresh operands.
  assign w_src_dvd  = i_start ? i_dividend : r_dvd;
  assign w_src_quot = i_start ? '0 : r_quot;
  assign w_src_rem  = i_start ? '0 : r_rem;
  assign w_src_dvs  = i_start ? i_divisor : r_dvs;
  assign w_sh       = {w_src_rem, w_src_dvd[SW-1]};
  assign w_diff     = w_sh - {1'b0, w_src_dvs};
  assign w_ge       = (w_sh >= {1'b0, w_src_dvs});
  assign w_last     = !i_start && (r_cnt == L_LAST);
  assign w_unused   = ^{w_diff[NW], w_src_quot[SW-1]};

  assign o_quot = r_quot;
  assign o_done = r_done;

  // One shift/compare/subtract step per active cycle.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_dvd    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start || r_active) begin
        r_rem    <= w_ge ? w_diff[NW-1:0] : w_sh[NW-1:0];
        r_dvd    <= w_src_dvd << 1;
        r_quot   <= {w_src_quot[SW-2:0], w_ge};
        r_dvs    <= w_src_dvs;
        r_cnt    <= i_start ? CW'(1) : r_cnt + 1'b1;
        r_active <= !w_last;
        r_done   <= w_last;
      end
    end
  end

endmodule

// File: rtl/vol_stats_finalize.sv
// End-of-window finalizer: turns sum / sum-of-squares / max / min into MEAN,
// RMS and peak-to-peak display codes with a fixed 78-cycle latency.
module vol_stats_finalize
  import vol_meas_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic       CLK,
  input  logic       RSTB,
  vol_stats_if.slave bus
);

  localparam int MSW = 2 * DW;
  localparam int CW  = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] L_DIV_LAST  = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] L_SQRT_LAST = CW'(SQRT_CYCLES - 1);
  localparam logic [DW-1:0] L_SAT       = DW'(SAT_MAX);

  function automatic logic [DW-1:0] sat_mean(input logic [SW-1:0] q);
    if (q > SW'(L_SAT)) return L_SAT;
    return q[DW-1:0];
  endfunction

  function automatic logic [MSW-1:0] clamp_ms(input logic [SW-1:0] q);
    if (q > SW'({MSW{1'b1}})) return '1;
    return q[MSW-1:0];
  endfunction

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_sum;
  logic [SW-1:0] r_sumsq;
  logic [NW-1:0] r_n;
  logic [DW-1:0] r_vpp;
  logic [DW-1:0] r_mean;
  logic [MSW-1:0] r_ms;
  logic [DW+3:0] r_srem;
  logic [DW-1:0] r_root;
  logic [DW-1:0] r_mean_out;
  logic [DW-1:0] r_rms_out;
  logic [DW-1:0] r_vpp_out;
  logic          r_valid;
  logic          r_busy;
  logic          r_div0;
  logic          r_ovr;

  logic [DW-1:0]  w_max;
  logic [DW-1:0]  w_min;
  logic [DW-1:0]  w_vpp;
  logic           w_div_start;
  logic [SW-1:0]  w_div_dvd;
  logic [SW-1:0]  w_quot;
  logic           w_div_done;
  logic [MSW-1:0] w_sq_ms;
  logic [DW+3:0]  w_sq_rem;
  logic [DW-1:0]  w_sq_root;
  logic [DW+3:0]  w_trial;
  logic [DW+3:0]  w_test;
  logic           w_sq_ge;
  logic           w_unused;

  // Only the low DW bits of max/min carry a code; an inverted pair reads as 0.
  assign w_max = bus.MAX_IN[DW-1:0];
  assign w_min = bus.MIN_IN[DW-1:0];
  assign w_vpp = (w_max >= w_min) ? (w_max - w_min) : '0;

  // The divider is shared: SUM/N in DIV_MEAN, SUMSQ/N in DIV_SQ. N=0 never starts it.
  assign w_div_start = ((r_state == DIV_MEAN) || (r_state == DIV_SQ)) &&
                       (r_cnt == '0) && (r_n != '0);
  assign w_div_dvd   = (r_state == DIV_SQ) ? r_sumsq : r_sum;

  serial_divider #(
    .SW (SW),
    .NW (NW)
  ) u_div (
    .CLK        (CLK),
    .RSTB       (RSTB),
    .i_start    (w_div_start),
    .i_dividend (w_div_dvd),
    .i_divisor  (r_n),
    .o_quot     (w_quot),
    .o_done     (w_div_done)
  );

  // Digit-by-digit root: each step brings in two radicand bits and decides one
  // root bit. The first step seeds from the clamped mean-square quotient.
  assign w_sq_ms   = (r_cnt == '0) ? clamp_ms(w_quot) : r_ms;
  assign w_sq_rem  = (r_cnt == '0) ? '0 : r_srem;
  assign w_sq_root = (r_cnt == '0) ? '0 : r_root;
  assign w_trial   = {w_sq_rem[DW+1:0], w_sq_ms[MSW-1 -: 2]};
  assign w_test    = {2'b00, w_sq_root, 2'b01};
  assign w_sq_ge   = (w_trial >= w_test);
  assign w_unused  = ^{bus.MAX_IN[SW-1:DW], bus.MIN_IN[SW-1:DW], w_sq_rem[DW+3:DW+2]};

  assign bus.MEAN_OUT     = r_mean_out;
  assign bus.RMS_OUT      = r_rms_out;
  assign bus.VPP_OUT      = r_vpp_out;
  assign bus.RESULT_VALID = r_valid;
  assign bus.BUSY         = r_busy;
  assign bus.ERR_DIV0     = r_div0;
  assign bus.ERR_OVERRUN  = r_ovr;

  // Sequencer: fixed-length phases so latency never depends on the data.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_sumsq    <= '0;
      r_n        <= '0;
      r_vpp      <= '0;
      r_mean     <= '0;
      r_ms       <= '0;
      r_srem     <= '0;
      r_root     <= '0;
      r_mean_out <= '0;
      r_rms_out  <= '0;
      r_vpp_out  <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_div0     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_div0  <= 1'b0;
      r_ovr   <= bus.MEAN_FLAG && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (bus.MEAN_FLAG) begin
            r_state <= CAPTURE;
            r_busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          r_sum   <= bus.SUM_IN;
          r_sumsq <= bus.SUMSQ_IN;
          r_n     <= bus.N_SAMPLES;
          r_vpp   <= w_vpp;
          r_cnt   <= '0;
          r_state <= DIV_MEAN;
        end
        DIV_MEAN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == L_DIV_LAST) begin
            r_cnt   <= '0;
            r_state <= DIV_SQ;
          end
        end
        DIV_SQ: begin
          if ((r_cnt == '0) && w_div_done) r_mean <= sat_mean(w_quot);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == L_DIV_LAST) begin
            r_cnt   <= '0;
            r_state <= SQRT;
          end
        end
        SQRT: begin
          r_ms   <= {w_sq_ms[MSW-3:0], 2'b00};
          r_srem <= w_sq_ge ? (w_trial - w_test) : w_trial;
          r_root <= {w_sq_root[DW-2:0], w_sq_ge};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == L_SQRT_LAST) begin
            r_cnt   <= '0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_valid   <= 1'b1;
          r_vpp_out <= r_vpp;
          if (r_n == '0) begin
            r_mean_out <= L_SAT;
            r_rms_out  <= L_SAT;
            r_div0     <= 1'b1;
          end else begin
            r_mean_out <= r_mean;
            r_rms_out  <= r_root;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vol_stats_finalize.sv
// Directed bench for vol_stats_finalize: latency, floor arithmetic, saturation,
// divide-by-zero, overrun, back-to-back windows and mid-operation reset.
module tb_vol_stats_finalize;
  import vol_meas_pkg::*;

  logic CLK;
  logic RSTB;
  int   total;
  int   bad;

  vol_stats_if bus ();

  vol_stats_finalize dut (
    .CLK  (CLK),
    .RSTB (RSTB),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Present one window's totals and strobe MEAN_FLAG for one edge (edge k).
  // Returns #1 after edge k with the strobe dropped and the data held.
  task automatic launch(input logic [31:0] s, input logic [31:0] sq,
                        input logic [31:0] mx, input logic [31:0] mn,
                        input logic [12:0] n);
    @(posedge CLK); #1;
    bus.SUM_IN    = s;
    bus.SUMSQ_IN  = sq;
    bus.MAX_IN    = mx;
    bus.MIN_IN    = mn;
    bus.N_SAMPLES = n;
    bus.MEAN_FLAG = 1'b1;
    @(posedge CLK); #1;
    bus.MEAN_FLAG = 1'b0;
  endtask

  // Step edges after cycle start_c until RESULT_VALID or a 120-cycle budget.
  task automatic wait_result(input int start_c, output int lat, output int drops,
                             output int ovr, output logic div0);
    lat = -1; drops = 0; ovr = 0; div0 = 1'b0;
    for (int c = start_c + 1; c <= start_c + 120; c++) begin
      @(posedge CLK); #1;
      if (bus.RESULT_VALID) begin
        lat  = c;
        div0 = bus.ERR_DIV0;
        break;
      end
      if (!bus.BUSY) drops++;
      if (bus.ERR_OVERRUN) ovr++;
    end
  endtask

  task automatic test_reset();
    RSTB = 1'b0;
    #12;
    total++; if (bus.MEAN_OUT !== 12'd0) begin bad++; $display("FAIL reset_mean got=%0d want=0", bus.MEAN_OUT); end
    total++; if (bus.RMS_OUT !== 12'd0) begin bad++; $display("FAIL reset_rms got=%0d want=0", bus.RMS_OUT); end
    total++; if (bus.VPP_OUT !== 12'd0) begin bad++; $display("FAIL reset_vpp got=%0d want=0", bus.VPP_OUT); end
    total++; if ({bus.RESULT_VALID, bus.BUSY, bus.ERR_DIV0, bus.ERR_OVERRUN} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {bus.RESULT_VALID, bus.BUSY, bus.ERR_DIV0, bus.ERR_OVERRUN}); end
    @(posedge CLK); #1;
    RSTB = 1'b1;
  endtask

  task automatic test_basic();
    int lat, drops, ovr; logic div0;
    launch(32'd4000, 32'd4_000_000, 32'd1000, 32'd1000, 13'd4);
    total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL t1_busy_start got=%b want=1", bus.BUSY); end
    wait_result(0, lat, drops, ovr, div0);
    total++; if (lat !== 78) begin bad++; $display("FAIL t1_latency got=%0d want=78", lat); end
    total++; if (drops !== 0) begin bad++; $display("FAIL t1_busy_drops got=%0d want=0", drops); end
    total++; if (bus.MEAN_OUT !== 12'd1000) begin bad++; $display("FAIL t1_mean got=%0d want=1000", bus.MEAN_OUT); end
    total++; if (bus.RMS_OUT !== 12'd1000) begin bad++; $display("FAIL t1_rms got=%0d want=1000", bus.RMS_OUT); end
    total++; if (bus.VPP_OUT !== 12'd0) begin bad++; $display("FAIL t1_vpp got=%0d want=0", bus.VPP_OUT); end
    total++; if (div0 !== 1'b0) begin bad++; $display("FAIL t1_div0 got=%b want=0", div0); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL t1_busy_done got=%b want=0", bus.BUSY); end
    @(posedge CLK); #1;
    total++; if (bus.RESULT_VALID !== 1'b0) begin bad++; $display("FAIL t1_valid_pulse got=%b want=0", bus.RESULT_VALID); end
    total++; if (bus.MEAN_OUT !== 12'd1000) begin bad++; $display("FAIL t1_mean_hold got=%0d want=1000", bus.MEAN_OUT); end
  endtask

  task automatic test_floor();
    int lat, drops, ovr; logic div0;
    launch(32'd7, 32'd10, 32'h0010_0BB8, 32'd1000, 13'd2);
    wait_result(0, lat, drops, ovr, div0);
    total++; if (lat !== 78) begin bad++; $display("FAIL t2_latency got=%0d want=78", lat); end
    total++; if (bus.MEAN_OUT !== 12'd3) begin bad++; $display("FAIL t2_mean got=%0d want=3", bus.MEAN_OUT); end
    total++; if (bus.RMS_OUT !== 12'd2) begin bad++; $display("FAIL t2_rms got=%0d want=2", bus.RMS_OUT); end
    total++; if (bus.VPP_OUT !== 12'd2000) begin bad++; $display("FAIL t2_vpp got=%0d want=2000", bus.VPP_OUT); end
  endtask

  task automatic test_div0();
    int lat, drops, ovr; logic div0;
    launch(32'd123, 32'd456, 32'd10, 32'd20, 13'd0);
    wait_result(0, lat, drops, ovr, div0);
    total++; if (lat !== 78) begin bad++; $display("FAIL t3_latency got=%0d want=78", lat); end
    total++; if (div0 !== 1'b1) begin bad++; $display("FAIL t3_div0 got=%b want=1", div0); end
    total++; if (bus.MEAN_OUT !== 12'd4095) begin bad++; $display("FAIL t3_mean got=%0d want=4095", bus.MEAN_OUT); end
    total++; if (bus.RMS_OUT !== 12'd4095) begin bad++; $display("FAIL t3_rms got=%0d want=4095", bus.RMS_OUT); end
    total++; if (bus.VPP_OUT !== 12'd0) begin bad++; $display("FAIL t3_vpp got=%0d want=0", bus.VPP_OUT); end
    @(posedge CLK); #1;
    total++; if (bus.ERR_DIV0 !== 1'b0) begin bad++; $display("FAIL t3_div0_pulse got=%b want=0", bus.ERR_DIV0); end
  endtask

  task automatic test_overrun();
    int lat, drops, ovr, extra, idle_busy; logic div0;
    drops = 0;
    launch(32'd800, 32'd80000, 32'd200, 32'd50, 13'd8);
    for (int c = 1; c <= 9; c++) begin
      @(posedge CLK); #1;
      if (!bus.BUSY) drops++;
      if (c == 9) begin
        bus.SUM_IN = 32'd1; bus.SUMSQ_IN = 32'd1; bus.MAX_IN = 32'd4000;
        bus.MIN_IN = 32'd0; bus.N_SAMPLES = 13'd1; bus.MEAN_FLAG = 1'b1;
      end
    end
    @(posedge CLK); #1;
    bus.MEAN_FLAG = 1'b0;
    total++; if (bus.ERR_OVERRUN !== 1'b1) begin bad++; $display("FAIL t4_overrun got=%b want=1", bus.ERR_OVERRUN); end
    total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL t4_busy_c10 got=%b want=1", bus.BUSY); end
    @(posedge CLK); #1;
    total++; if (bus.ERR_OVERRUN !== 1'b0) begin bad++; $display("FAIL t4_overrun_pulse got=%b want=0", bus.ERR_OVERRUN); end
    total++; if (drops !== 0) begin bad++; $display("FAIL t4_busy_early got=%0d want=0", drops); end
    wait_result(11, lat, drops, ovr, div0);
    total++; if (lat !== 78) begin bad++; $display("FAIL t4_latency got=%0d want=78", lat); end
    total++; if (drops !== 0) begin bad++; $display("FAIL t4_busy_drops got=%0d want=0", drops); end
    total++; if (ovr !== 0) begin bad++; $display("FAIL t4_overrun_extra got=%0d want=0", ovr); end
    total++; if (bus.MEAN_OUT !== 12'd100) begin bad++; $display("FAIL t4_mean got=%0d want=100", bus.MEAN_OUT); end
    total++; if (bus.RMS_OUT !== 12'd100) begin bad++; $display("FAIL t4_rms got=%0d want=100", bus.RMS_OUT); end
    total++; if (bus.VPP_OUT !== 12'd150) begin bad++; $display("FAIL t4_vpp got=%0d want=150", bus.VPP_OUT); end
    extra = 0; idle_busy = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge CLK); #1;
      if (bus.RESULT_VALID) extra++;
      if (bus.BUSY) idle_busy++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL t4_second_valid got=%0d want=0", extra); end
    total++; if (idle_busy !== 0) begin bad++; $display("FAIL t4_restart got=%0d want=0", idle_busy); end
  endtask

  task automatic test_reset_mid();
    int lat, drops, ovr, extra, busy_seen; logic div0;
    launch(32'd800, 32'd80000, 32'd200, 32'd50, 13'd8);
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK); #1;
    end
    RSTB = 1'b0;
    #1;
    total++; if (bus.MEAN_OUT !== 12'd0) begin bad++; $display("FAIL t5_mean got=%0d want=0", bus.MEAN_OUT); end
    total++; if (bus.RMS_OUT !== 12'd0) begin bad++; $display("FAIL t5_rms got=%0d want=0", bus.RMS_OUT); end
    total++; if (bus.VPP_OUT !== 12'd0) begin bad++; $display("FAIL t5_vpp got=%0d want=0", bus.VPP_OUT); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL t5_busy got=%b want=0", bus.BUSY); end
    repeat (3) @(posedge CLK);
    #1;
    RSTB = 1'b1;
    extra = 0; busy_seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge CLK); #1;
      if (bus.RESULT_VALID) extra++;
      if (bus.BUSY) busy_seen++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL t5_no_valid got=%0d want=0", extra); end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL t5_stays_idle got=%0d want=0", busy_seen); end
    launch(32'd32768, 32'd67108864, 32'd3000, 32'd3001, 13'd16);
    wait_result(0, lat, drops, ovr, div0);
    total++; if (lat !== 78) begin bad++; $display("FAIL t5_latency got=%0d want=78", lat); end
    total++; if (bus.MEAN_OUT !== 12'd2048) begin bad++; $display("FAIL t5_mean2 got=%0d want=2048", bus.MEAN_OUT); end
    total++; if (bus.RMS_OUT !== 12'd2048) begin bad++; $display("FAIL t5_rms2 got=%0d want=2048", bus.RMS_OUT); end
    total++; if (bus.VPP_OUT !== 12'd0) begin bad++; $display("FAIL t5_vpp2 got=%0d want=0", bus.VPP_OUT); end
  endtask

  task automatic test_saturate();
    int lat, drops, ovr; logic div0;
    launch(32'd5000, 32'd16_769_025, 32'd4095, 32'd0, 13'd1);
    wait_result(0, lat, drops, ovr, div0);
    total++; if (lat !== 78) begin bad++; $display("FAIL t6_latency got=%0d want=78", lat); end
    total++; if (bus.MEAN_OUT !== 12'd4095) begin bad++; $display("FAIL t6_mean got=%0d want=4095", bus.MEAN_OUT); end
    total++; if (bus.RMS_OUT !== 12'd4095) begin bad++; $display("FAIL t6_rms got=%0d want=4095", bus.RMS_OUT); end
    total++; if (bus.VPP_OUT !== 12'd4095) begin bad++; $display("FAIL t6_vpp got=%0d want=4095", bus.VPP_OUT); end
    total++; if (div0 !== 1'b0) begin bad++; $display("FAIL t6_div0 got=%b want=0", div0); end
  endtask

  task automatic test_back_to_back();
    int lat, drops, ovr, early; logic div0;
    early = 0;
    launch(32'd10, 32'd100, 32'd50, 32'd5, 13'd3);
    for (int c = 1; c <= 77; c++) begin
      @(posedge CLK); #1;
      if (bus.RESULT_VALID) early++;
      if (c == 77) begin
        bus.SUM_IN = 32'd20000; bus.SUMSQ_IN = 32'd5_000_000; bus.MAX_IN = 32'd4095;
        bus.MIN_IN = 32'd4095; bus.N_SAMPLES = 13'd5; bus.MEAN_FLAG = 1'b1;
      end
    end
    @(posedge CLK); #1;
    total++; if (early !== 0) begin bad++; $display("FAIL bb_early_valid got=%0d want=0", early); end
    total++; if (bus.RESULT_VALID !== 1'b1) begin bad++; $display("FAIL bb_valid_a got=%b want=1", bus.RESULT_VALID); end
    total++; if (bus.ERR_OVERRUN !== 1'b1) begin bad++; $display("FAIL bb_done_overrun got=%b want=1", bus.ERR_OVERRUN); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL bb_busy_a got=%b want=0", bus.BUSY); end
    total++; if (bus.MEAN_OUT !== 12'd3) begin bad++; $display("FAIL bb_mean_a got=%0d want=3", bus.MEAN_OUT); end
    total++; if (bus.RMS_OUT !== 12'd5) begin bad++; $display("FAIL bb_rms_a got=%0d want=5", bus.RMS_OUT); end
    total++; if (bus.VPP_OUT !== 12'd45) begin bad++; $display("FAIL bb_vpp_a got=%0d want=45", bus.VPP_OUT); end
    @(posedge CLK); #1;
    bus.MEAN_FLAG = 1'b0;
    total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL bb_accept got=%b want=1", bus.BUSY); end
    total++; if (bus.ERR_OVERRUN !== 1'b0) begin bad++; $display("FAIL bb_idle_overrun got=%b want=0", bus.ERR_OVERRUN); end
    wait_result(79, lat, drops, ovr, div0);
    total++; if (lat !== 157) begin bad++; $display("FAIL bb_latency_b got=%0d want=157", lat); end
    total++; if (bus.MEAN_OUT !== 12'd4000) begin bad++; $display("FAIL bb_mean_b got=%0d want=4000", bus.MEAN_OUT); end
    total++; if (bus.RMS_OUT !== 12'd1000) begin bad++; $display("FAIL bb_rms_b got=%0d want=1000", bus.RMS_OUT); end
    total++; if (bus.VPP_OUT !== 12'd0) begin bad++; $display("FAIL bb_vpp_b got=%0d want=0", bus.VPP_OUT); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.MEAN_FLAG = 1'b0;
    bus.SUM_IN    = '0;
    bus.SUMSQ_IN  = '0;
    bus.MAX_IN    = '0;
    bus.MIN_IN    = '0;
    bus.N_SAMPLES = '0;
    test_reset();
    test_basic();
    test_floor();
    test_div0();
    test_overrun();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog elapsed=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule
